// File: rtl/can_frame_player_pkg.sv
// rtl/can_frame_player_pkg.sv - shared encodings for the CAN frame player
// Purpose: FSM state codes, CAN bit levels, stuffing run length and the
//          run-length update helper used by the player top level.
// Ports:   none (package).
package can_frame_player_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DATA = 2'd1;
  localparam state_t ST_TAIL = 2'd2;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  localparam int unsigned CAN_STUFF_RUN = 5;
  localparam int unsigned RUN_W         = 3;

  // Length of the run of equal bits after driving one more bit. Saturates so
  // long unstuffed runs cannot wrap back to the stuffing threshold.
  function automatic logic [RUN_W-1:0] run_next(input logic [RUN_W-1:0] run,
                                                input logic             same_bit);
    if (!same_bit) begin
      return RUN_W'(1);
    end
    if (run == '1) begin
      return run;
    end
    return run + RUN_W'(1);
  endfunction

endpackage

// File: rtl/can_frame_player_bit_timer.sv
// rtl/can_frame_player_bit_timer.sv - time-quantum counter producing per-bit strobes
// Purpose: counts tq_cnt 0..CLK_PER_BIT-1 while enabled, held at 0 otherwise.
// Ports:
//   clk            in  clock
//   rst            in  synchronous reset, active-low
//   en_i           in  count enable (player busy)
//   bit_start_o    out first cycle of a bit
//   sample_point_o out cycle SAMPLE_POS of a bit
//   bit_end_o      out last cycle of a bit (counter wraps next edge)
module can_frame_player_bit_timer #(
  parameter int unsigned CLK_PER_BIT = 10,
  parameter int unsigned SAMPLE_POS  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic bit_start_o,
  output logic sample_point_o,
  output logic bit_end_o
);

  localparam int unsigned TQ_W = $clog2(CLK_PER_BIT);
  localparam logic [TQ_W-1:0] TQ_LAST   = TQ_W'(CLK_PER_BIT - 1);
  localparam logic [TQ_W-1:0] TQ_SAMPLE = TQ_W'(SAMPLE_POS);

  logic [TQ_W-1:0] tq_cnt_q;
  logic [TQ_W-1:0] tq_cnt_d;

  always_comb begin
    tq_cnt_d = tq_cnt_q;
    if (!en_i) begin
      tq_cnt_d = '0;
    end else if (tq_cnt_q == TQ_LAST) begin
      tq_cnt_d = '0;
    end else begin
      tq_cnt_d = tq_cnt_q + TQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tq_cnt_q <= '0;
    end else begin
      tq_cnt_q <= tq_cnt_d;
    end
  end

  assign bit_start_o    = en_i && (tq_cnt_q == '0);
  assign sample_point_o = en_i && (tq_cnt_q == TQ_SAMPLE);
  assign bit_end_o      = en_i && (tq_cnt_q == TQ_LAST);

endmodule

// File: rtl/can_frame_player.sv
// rtl/can_frame_player.sv - CAN bit-stream source with stuffing and EOF/IFS tail
// Purpose: plays a latched frame MSB-first on tx_bit with programmable bit
//          timing, optional stuff-bit insertion and TAIL_BITS recessive bits.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start         play request, taken only when idle and not in the done cycle
//   frame_bits    frame vector, bit [frame_len-1] sent first
//   frame_len     frame length, saturated to MAX_LEN
//   stuff_len     leading frame bits subject to stuffing
//   stuff_en      enable stuff-bit insertion
//   tx_bit        serial output, 1 = recessive
//   sample_point  pulse at SAMPLE_POS of every bit
//   bit_start     pulse on the first cycle of every bit
//   is_stuff      high for the whole of an inserted stuff bit
//   busy          high while a frame is playing
//   done          one-cycle pulse after the last tail bit
//   bits_sent     bits driven in the current/last frame
module can_frame_player
  import can_frame_player_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 512,
  parameter int unsigned LEN_W       = 10,
  parameter int unsigned CLK_PER_BIT = 10,
  parameter int unsigned SAMPLE_POS  = 7,
  parameter int unsigned TAIL_BITS   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] frame_bits,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic [LEN_W-1:0]   stuff_len,
  input  logic               stuff_en,
  output logic               tx_bit,
  output logic               sample_point,
  output logic               bit_start,
  output logic               is_stuff,
  output logic               busy,
  output logic               done,
  output logic [LEN_W+3:0]   bits_sent
);

  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TAIL_W = $clog2(TAIL_BITS + 1);
  localparam int unsigned BS_W   = LEN_W + 4;
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_BITS);

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tx_q, tx_d;
  logic               is_stuff_q, is_stuff_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [TAIL_W-1:0]  tail_q, tail_d;
  logic [BS_W-1:0]    bits_sent_q, bits_sent_d;

  // Frame configuration captured at acceptance; no reset needed, it is
  // always written before being used.
  logic [MAX_LEN-1:0] frame_q, frame_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   stuff_len_q, stuff_len_d;
  logic               stuff_en_q, stuff_en_d;

  logic               tm_bit_end;
  logic [LEN_W-1:0]   len_sat;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   next_idx;
  logic               next_frame_bit;
  logic [LEN_W-1:0]   consumed;
  logic               stuff_due;
  logic               accept;

  can_frame_player_bit_timer #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .SAMPLE_POS  (SAMPLE_POS)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .en_i           (busy_q),
    .bit_start_o    (bit_start),
    .sample_point_o (sample_point),
    .bit_end_o      (tm_bit_end)
  );

  assign len_sat   = (frame_len > MAX_LEN_L) ? MAX_LEN_L : frame_len;
  assign first_idx = IDX_W'(len_sat - LEN_W'(1));
  assign next_idx  = idx_q - IDX_W'(1);
  assign next_frame_bit = frame_q[next_idx];

  // idx_q points at the most recent frame bit driven (it is kept across a
  // stuff bit), so len_q - idx_q is the number of frame bits consumed.
  assign consumed  = len_q - LEN_W'(idx_q);
  assign stuff_due = stuff_en_q && (consumed <= stuff_len_q)
                     && (run_q == RUN_W'(CAN_STUFF_RUN));

  // The done cycle is already IDLE; a start seen there must not restart.
  assign accept = (state_q == ST_IDLE) && start && !done_q;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_d        = tx_q;
    is_stuff_d  = is_stuff_q;
    idx_d       = idx_q;
    run_d       = run_q;
    tail_d      = tail_q;
    bits_sent_d = bits_sent_q;
    frame_d     = frame_q;
    len_d       = len_q;
    stuff_len_d = stuff_len_q;
    stuff_en_d  = stuff_en_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = CAN_RECESSIVE;
        if (accept) begin
          frame_d     = frame_bits;
          len_d       = len_sat;
          stuff_len_d = stuff_len;
          stuff_en_d  = stuff_en;
          busy_d      = 1'b1;
          is_stuff_d  = 1'b0;
          bits_sent_d = BS_W'(1);
          if (len_sat == '0) begin
            state_d = ST_TAIL;
            tail_d  = TAIL_W'(1);
            idx_d   = '0;
            run_d   = '0;
          end else begin
            state_d = ST_DATA;
            idx_d   = first_idx;
            tx_d    = frame_bits[first_idx];
            run_d   = RUN_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tm_bit_end) begin
          bits_sent_d = bits_sent_q + BS_W'(1);
          if (stuff_due) begin
            tx_d       = (tx_q == CAN_DOMINANT) ? CAN_RECESSIVE : CAN_DOMINANT;
            is_stuff_d = 1'b1;
            run_d      = RUN_W'(1);
          end else if (idx_q == '0) begin
            state_d    = ST_TAIL;
            tx_d       = CAN_RECESSIVE;
            is_stuff_d = 1'b0;
            tail_d     = TAIL_W'(1);
          end else begin
            idx_d      = next_idx;
            tx_d       = next_frame_bit;
            is_stuff_d = 1'b0;
            run_d      = run_next(run_q, next_frame_bit == tx_q);
          end
        end
      end

      ST_TAIL: begin
        if (tm_bit_end) begin
          if (tail_q == TAIL_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tail_d  = '0;
          end else begin
            tail_d      = tail_q + TAIL_W'(1);
            bits_sent_d = bits_sent_q + BS_W'(1);
            tx_d        = CAN_RECESSIVE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        tx_d    = CAN_RECESSIVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= CAN_RECESSIVE;
      is_stuff_q  <= 1'b0;
      idx_q       <= '0;
      run_q       <= '0;
      tail_q      <= '0;
      bits_sent_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
      is_stuff_q  <= is_stuff_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      tail_q      <= tail_d;
      bits_sent_q <= bits_sent_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q     <= frame_d;
    len_q       <= len_d;
    stuff_len_q <= stuff_len_d;
    stuff_en_q  <= stuff_en_d;
  end

  assign tx_bit    = tx_q;
  assign is_stuff  = is_stuff_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bits_sent = bits_sent_q;

endmodule
